// File: rtl/posit_result_writer.sv
// Write-back stage for the posit FU: buffers tagged result records and emits one
// CCI-P c1 byte-mode line write per record, with outstanding-write tracking and a flush handshake.
module posit_result_writer #(
    parameter int DEPTH   = 8,
    parameter int MAX_OUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [41:0]  cfg_base_addr,
    input  logic [5:0]   cfg_gran,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_tag,
    input  logic [36:0]  in_rec,
    input  logic         tx_almfull,
    output logic         wr_valid,
    output logic [41:0]  wr_addr,
    output logic [5:0]   wr_byte_start,
    output logic [5:0]   wr_byte_len,
    output logic [511:0] wr_data,
    input  logic         wr_rsp_valid,
    input  logic         flush_req,
    output logic         flush_done,
    output logic [4:0]   outstanding
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] OUT_CAP = 5'(MAX_OUT);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [44:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, issue, rsp_eff;

    logic [44:0]  head;
    logic [7:0]   head_tag;
    logic [36:0]  head_rec;
    logic [11:0]  off;
    logic [511:0] word;
    logic [8:0]   shift;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Gated with reset_n so every output reads 0 while reset is held.
    assign in_ready = reset_n && !full && (state_q == S_RUN) && !flush_req;
    assign push     = in_valid && in_ready;
    assign issue    = !empty && !tx_almfull && (outstanding < OUT_CAP);
    assign rsp_eff  = wr_rsp_valid && (outstanding != 5'd0);

    assign head     = mem[rd_ptr[AW-1:0]];
    assign head_tag = head[44:37];
    assign head_rec = head[36:0];

    // Slot offset in bytes; only the low 12 bits are meaningful to the address math.
    assign off   = {6'b0, cfg_gran} * {4'b0, head_tag};
    assign word  = {475'b0, head_rec};
    assign shift = {off[5:0], 3'b000};

    // NOTE: storage array has no reset; validity comes solely from the reset pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in_tag, in_rec};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_byte_start <= '0;
            wr_byte_len   <= '0;
            wr_data       <= '0;
        end else begin
            wr_valid <= issue;
            if (issue) begin
                wr_addr       <= cfg_base_addr + {36'b0, off[11:6]};
                wr_byte_start <= off[5:0];
                wr_byte_len   <= cfg_gran;
                wr_data       <= word << shift;
            end
        end
    end

    // A response with nothing outstanding is spurious and never lowers the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            unique case ({issue, rsp_eff})
                2'b10:   outstanding <= outstanding + 5'd1;
                2'b01:   outstanding <= outstanding - 5'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_RUN;
        else          state_q <= state_d;
    end

    // NOTE: next state is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (flush_req) state_d = S_DRAIN;
            S_DRAIN: if (empty && (outstanding == 5'd0) && !issue) state_d = S_DONE;
            S_DONE:  if (!flush_req) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    assign flush_done = (state_q == S_DONE);

endmodule

// File: tb/tb_posit_result_writer.sv
// Self-checking bench for posit_result_writer: scoreboard of expected c1 writes
// built from a byte-level model, plus directed checks of flow control, flush and reset.
`timescale 1ns/1ps
module tb_posit_result_writer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [41:0]  cfg_base_addr;
    logic [5:0]   cfg_gran;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_tag;
    logic [36:0]  in_rec;
    logic         tx_almfull;
    logic         wr_valid;
    logic [41:0]  wr_addr;
    logic [5:0]   wr_byte_start;
    logic [5:0]   wr_byte_len;
    logic [511:0] wr_data;
    logic         wr_rsp_valid;
    logic         flush_req;
    logic         flush_done;
    logic [4:0]   outstanding;

    typedef struct {
        logic [41:0]  addr;
        logic [5:0]   bs;
        logic [5:0]   len;
        logic [511:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_total = 0;

    always #5 clk = ~clk;

    posit_result_writer #(.DEPTH(8), .MAX_OUT(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_base_addr (cfg_base_addr),
        .cfg_gran      (cfg_gran),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_tag        (in_tag),
        .in_rec        (in_rec),
        .tx_almfull    (tx_almfull),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_byte_start (wr_byte_start),
        .wr_byte_len   (wr_byte_len),
        .wr_data       (wr_data),
        .wr_rsp_valid  (wr_rsp_valid),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .outstanding   (outstanding)
    );

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Places the five record bytes one at a time at the slot's byte offset.
    function automatic exp_t model(input logic [7:0] tag, input logic [36:0] rec);
        exp_t        m;
        int          off;
        int          bsi;
        logic [39:0] w;
        off    = (int'(cfg_gran) * int'(tag)) % 4096;
        bsi    = off % 64;
        m.addr = cfg_base_addr + 42'(off / 64);
        m.bs   = 6'(bsi);
        m.len  = cfg_gran;
        m.data = '0;
        w      = {3'b000, rec};
        for (int b = 0; b < 5; b++)
            if (bsi + b < 64) m.data[(bsi + b) * 8 +: 8] = w[b * 8 +: 8];
        return m;
    endfunction

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_total++;
            if (sb.size() == 0) begin
                check("spurious_wr", 512'(wr_valid), 512'(0));
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", 512'(wr_addr), 512'(mon_e.addr));
                check("wr_byte_start", 512'(wr_byte_start), 512'(mon_e.bs));
                check("wr_byte_len", 512'(wr_byte_len), 512'(mon_e.len));
                check("wr_data", wr_data, mon_e.data);
            end
        end
    end

    task automatic push(input logic [7:0] tag, input logic [36:0] rec);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_tag   = tag;
        in_rec   = rec;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (ok) sb.push_back(model(tag, rec));
        else    check("push_timeout", 512'(ok), 512'(1));
    endtask

    task automatic respond(input int n);
        for (int i = 0; i < n; i++) begin
            wr_rsp_valid = 1'b1;
            @(posedge clk); #1;
            wr_rsp_valid = 1'b0;
        end
    endtask

    function automatic logic [36:0] rnd_rec();
        return 37'({$urandom(), $urandom()});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        int   run;
        logic got;

        reset_n       = 1'b0;
        cfg_base_addr = 42'h100;
        cfg_gran      = 6'd4;
        in_valid      = 1'b0;
        in_tag        = '0;
        in_rec        = '0;
        tx_almfull    = 1'b0;
        wr_rsp_valid  = 1'b0;
        flush_req     = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_wr_valid", 512'(wr_valid), 512'(0));
        check("rst_flush_done", 512'(flush_done), 512'(0));
        check("rst_outstanding", 512'(outstanding), 512'(0));
        check("rst_wr_addr", 512'(wr_addr), 512'(0));
        check("rst_wr_bs", 512'(wr_byte_start), 512'(0));
        check("rst_wr_len", 512'(wr_byte_len), 512'(0));
        check("rst_wr_data", wr_data, 512'(0));
        #10 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 512'(in_ready), 512'(1));

        // Single write and its latency
        push(8'd20, 37'h0_1234_5678);
        @(negedge clk);
        check("lat_early", 512'(wr_valid), 512'(0));
        @(negedge clk);
        check("lat_wr_valid", 512'(wr_valid), 512'(1));
        check("single_addr", 512'(wr_addr), 512'(42'h101));
        check("single_bs", 512'(wr_byte_start), 512'(16));
        check("single_word", 512'(wr_data[159:128]), 512'(32'h1234_5678));
        check("single_out", 512'(outstanding), 512'(1));
        respond(1);
        @(negedge clk);
        check("single_out_rsp", 512'(outstanding), 512'(0));

        // Backpressure: fill the FIFO under almfull, then release a burst
        tx_almfull = 1'b1;
        t0 = wr_total;
        for (int i = 0; i < 8; i++) push(8'(i * 7), rnd_rec());
        @(negedge clk);
        check("bp_full_ready", 512'(in_ready), 512'(0));
        repeat (5) @(negedge clk);
        check("bp_no_write", 512'(wr_total - t0), 512'(0));
        tx_almfull = 1'b0;
        run = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr_valid) run++;
            else if (run > 0) break;
        end
        check("bp_burst_len", 512'(run), 512'(8));
        check("bp_ready_back", 512'(in_ready), 512'(1));
        check("bp_out", 512'(outstanding), 512'(8));
        respond(8);
        @(negedge clk);
        check("bp_out_zero", 512'(outstanding), 512'(0));

        // Outstanding cap with no responses
        cfg_gran      = 6'd5;
        cfg_base_addr = 42'h3000;
        t0 = wr_total;
        for (int i = 0; i < 20; i++) push(8'(i * 3), rnd_rec());
        repeat (6) @(negedge clk);
        check("cap_writes", 512'(wr_total - t0), 512'(16));
        check("cap_out", 512'(outstanding), 512'(16));
        for (int k = 0; k < 4; k++) begin
            respond(1);
            repeat (3) @(negedge clk);
            check("cap_release", 512'(wr_total - t0), 512'(17 + k));
            check("cap_out_hold", 512'(outstanding), 512'(16));
        end
        repeat (3) @(negedge clk);
        check("cap_total", 512'(wr_total - t0), 512'(20));
        respond(16);
        @(negedge clk);
        check("cap_out_zero", 512'(outstanding), 512'(0));

        // Simultaneous issue and response; response at zero
        cfg_gran      = 6'd4;
        cfg_base_addr = 42'h100;
        for (int i = 0; i < 5; i++) push(8'(40 + i), rnd_rec());
        repeat (4) @(negedge clk);
        check("sim_out5", 512'(outstanding), 512'(5));
        tx_almfull = 1'b1;
        t0 = wr_total;
        push(8'd60, rnd_rec());
        repeat (3) @(negedge clk);
        check("sim_almfull_hold", 512'(wr_total - t0), 512'(0));
        tx_almfull   = 1'b0;
        wr_rsp_valid = 1'b1;
        @(posedge clk); #1;
        wr_rsp_valid = 1'b0;
        @(negedge clk);
        check("sim_wr_valid", 512'(wr_valid), 512'(1));
        check("sim_out_same", 512'(outstanding), 512'(5));
        respond(5);
        @(negedge clk);
        check("sim_out_zero", 512'(outstanding), 512'(0));
        respond(1);
        @(negedge clk);
        check("rsp_at_zero", 512'(outstanding), 512'(0));

        // Flush with 2 outstanding and 3 queued
        for (int i = 0; i < 2; i++) push(8'(70 + i), rnd_rec());
        repeat (4) @(negedge clk);
        check("fl_out2", 512'(outstanding), 512'(2));
        tx_almfull = 1'b1;
        for (int i = 0; i < 3; i++) push(8'(80 + i), rnd_rec());
        flush_req = 1'b1;
        @(negedge clk);
        check("fl_ready_low", 512'(in_ready), 512'(0));
        repeat (3) @(negedge clk);
        check("fl_not_done_q", 512'(flush_done), 512'(0));
        tx_almfull = 1'b0;
        repeat (5) @(negedge clk);
        check("fl_out5", 512'(outstanding), 512'(5));
        check("fl_not_done_o", 512'(flush_done), 512'(0));
        respond(4);
        @(negedge clk);
        check("fl_not_done_r", 512'(flush_done), 512'(0));
        respond(1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = flush_done;
        end
        check("fl_done", 512'(got), 512'(1));
        check("fl_done_ready", 512'(in_ready), 512'(0));
        check("fl_done_out", 512'(outstanding), 512'(0));
        flush_req = 1'b0;
        @(negedge clk);
        check("fl_run_ready", 512'(in_ready), 512'(1));
        check("fl_run_done", 512'(flush_done), 512'(0));

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 2; i++) push(8'(90 + i), rnd_rec());
        repeat (4) @(negedge clk);
        tx_almfull = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(100 + i), rnd_rec());
        tx_almfull = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("ar_wr_valid", 512'(wr_valid), 512'(0));
        check("ar_out", 512'(outstanding), 512'(0));
        check("ar_in_ready", 512'(in_ready), 512'(0));
        check("ar_wr_addr", 512'(wr_addr), 512'(0));
        check("ar_wr_data", wr_data, 512'(0));
        check("ar_flush_done", 512'(flush_done), 512'(0));
        sb.delete();
        @(negedge clk); #2;
        reset_n = 1'b1;
        t0 = wr_total;
        repeat (10) @(negedge clk);
        check("ar_no_spurious", 512'(wr_total - t0), 512'(0));
        check("ar_out_after", 512'(outstanding), 512'(0));
        check("ar_ready_after", 512'(in_ready), 512'(1));
        push(8'd33, rnd_rec());
        repeat (4) @(negedge clk);
        check("ar_resume_out", 512'(outstanding), 512'(1));
        respond(1);
        repeat (2) @(negedge clk);
        check("sb_drained", 512'(sb.size()), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
